// File: rtl/bank_loader_pkg.sv
// Shared constants and state encoding for the 4-bank operand buffer writer and its consumer.
package bank_loader_pkg;

  localparam int unsigned DEPTH  = 36;
  localparam int unsigned BANKS  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned BANK_W = 2;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    FULL      = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/bank_loader_fsm_bank_addr_counter.sv
// Bank/word address counter: walks addr 0..DEPTH-1 within a bank, then advances the bank.
module bank_addr_counter
  import bank_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr_cnt,
  output logic [BANK_W-1:0] bank_cnt,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              addr_wrap;
  logic              bank_wrap;

  // >= rather than == so an out-of-range count can only ever wrap back to 0
  assign addr_wrap = (addr_q >= ADDR_W'(DEPTH - 1));
  assign bank_wrap = (bank_q >= BANK_W'(BANKS - 1));

  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    if (clr) begin
      addr_d = '0;
      bank_d = '0;
    end else if (inc) begin
      if (addr_wrap) begin
        addr_d = '0;
        bank_d = bank_wrap ? '0 : bank_q + BANK_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      bank_q <= '0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end

  assign addr_cnt = addr_q;
  assign bank_cnt = bank_q;
  assign last     = (bank_q == BANK_W'(BANKS - 1)) && (addr_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/bank_loader_fsm.sv
// Writer-side loader: fills 4 banks x 36 words from a valid/ready stream, then hands off to the consumer.
// Optional sticky protocol checker enabled by defining LOADER_PROTO_CHECK_EN (adds port load_err).
module bank_loader_fsm
  import bank_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              data_rdy,
  input  logic              data_done
`ifdef LOADER_PROTO_CHECK_EN
  ,
  output logic              load_err
`endif
);

  loader_state_t     state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              data_rdy_q, data_rdy_d;

  logic              cnt_inc;
  logic              cnt_clr;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BANK_W-1:0] bank_cnt;
  logic              cnt_last;

  bank_addr_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .addr_cnt (addr_cnt),
    .bank_cnt (bank_cnt),
    .last     (cnt_last)
  );

  // Ready depends on state alone so the stream side never sees a valid->ready loop
  assign in_ready = (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    wr_en_d    = 1'b0;
    wr_bank_d  = wr_bank_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    data_rdy_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          cnt_inc   = 1'b1;
          wr_en_d   = 1'b1;
          wr_bank_d = bank_cnt;
          wr_addr_d = addr_cnt;
          wr_data_d = in_data;
          // Pulse lines up with the final write, which lands in the FULL cycle
          if (cnt_last) begin
            state_d    = FULL;
            data_rdy_d = 1'b1;
          end
        end
      end
      FULL: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (data_done) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      data_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      data_rdy_q <= data_rdy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_bank  = wr_bank_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign data_rdy = data_rdy_q;

`ifdef LOADER_PROTO_CHECK_EN
  localparam int unsigned STALL_MAX = 4 * DEPTH;
  localparam int unsigned STALL_W   = $clog2(STALL_MAX + 1);

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               load_err_q, load_err_d;
  logic               stall_cond;
  logic               err_set;

  // Consumer hang: producer keeps offering words while we are parked past the limit
  always_comb begin
    stall_cond  = in_valid && ((state_q == FULL) || (state_q == WAIT_DONE));
    stall_cnt_d = '0;
    if (stall_cond) begin
      stall_cnt_d = (stall_cnt_q >= STALL_W'(STALL_MAX)) ? stall_cnt_q
                                                         : stall_cnt_q + STALL_W'(1);
    end
    err_set    = (data_done && (state_q != WAIT_DONE)) ||
                 (stall_cond && (stall_cnt_q >= STALL_W'(STALL_MAX)));
    load_err_d = load_err_q | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      load_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      load_err_q  <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`endif

endmodule
